// File: rtl/sample_stream_mem.sv
// Sample store with a command-driven streaming read engine feeding a valid/ready sample stream.
// Define SAMPLE_MEM_WRPORT_EN to add a synchronous write port (wr_en/wr_addr/wr_data).
module sample_stream_mem #(
    parameter int unsigned ENTRY_W  = 32,
    parameter int unsigned DIM      = 4,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter string       MEM_INIT = ""
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_base,
    input  logic [ADDR_W:0]        cmd_count,
    input  logic                   cmd_loop,
    input  logic                   stop,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIM*ENTRY_W-1:0] out_data,
    output logic [ADDR_W-1:0]      out_index,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
`ifdef SAMPLE_MEM_WRPORT_EN
    ,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DIM*ENTRY_W-1:0] wr_data
`endif
);

    localparam int unsigned DW = DIM * ENTRY_W;
    localparam int unsigned CW = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state, state_n;
    logic [DW-1:0]     mem [DEPTH];
    logic [DW-1:0]     mem_q;
    logic              rd_vld;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_last;

    logic [ADDR_W-1:0] addr_q, base_q;
    logic [CW-1:0]     count_q, k_q;
    logic              loop_q;

    logic              s_valid;
    logic [DW-1:0]     s_data;
    logic [ADDR_W-1:0] s_idx;
    logic              s_last;

    logic              issue_c, finish_c, last_c, credit_c, drained_c, abort_c, pop_c;
    logic [ADDR_W-1:0] rd_addr_c, pass_base_c, addr_inc_c;
    logic [CW-1:0]     pass_cnt_c, pass_k_c;
    logic              pass_loop_c;

    // Reads are only issued when the in-flight read has a guaranteed slot in the 2-entry buffer.
    assign pop_c     = out_valid & out_ready;
    assign credit_c  = (2'(out_valid) + 2'(s_valid) + 2'(rd_vld) - 2'(pop_c)) < 2'd2;
    assign drained_c = !rd_vld && !s_valid && (!out_valid || out_ready);
    assign abort_c   = stop && (state != IDLE);
    assign addr_inc_c = (rd_addr_c == ADDR_W'(DEPTH - 1)) ? '0 : rd_addr_c + ADDR_W'(1);

    always_comb begin
        state_n     = state;
        issue_c     = 1'b0;
        finish_c    = 1'b0;
        last_c      = 1'b0;
        rd_addr_c   = addr_q;
        pass_base_c = base_q;
        pass_cnt_c  = count_q;
        pass_k_c    = k_q;
        pass_loop_c = loop_q;
        case (state)
            IDLE: begin
                rd_addr_c   = cmd_base;
                pass_base_c = cmd_base;
                pass_cnt_c  = cmd_count;
                pass_k_c    = '0;
                pass_loop_c = cmd_loop;
                if (cmd_valid) begin
                    if (cmd_count == '0) begin
                        finish_c = 1'b1;
                    end else begin
                        issue_c = 1'b1;
                        state_n = FETCH;
                    end
                end
            end
            FETCH: issue_c = credit_c;
            DRAIN: begin
                if (drained_c) begin
                    state_n  = IDLE;
                    finish_c = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        last_c = (pass_k_c == pass_cnt_c - CW'(1));
        if (issue_c && last_c && !pass_loop_c) state_n = DRAIN;
        if (abort_c) begin
            state_n  = IDLE;
            issue_c  = 1'b0;
            finish_c = 1'b1;
        end
    end

    // Storage is never reset; read data has one clock of latency and sees pre-write contents.
    always_ff @(posedge clk) begin
        if (issue_c) mem_q <= mem[rd_addr_c];
`ifdef SAMPLE_MEM_WRPORT_EN
        if (wr_en) mem[wr_addr] <= wr_data;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_vld    <= 1'b0;
            rd_idx    <= '0;
            rd_last   <= 1'b0;
            addr_q    <= '0;
            base_q    <= '0;
            count_q   <= '0;
            k_q       <= '0;
            loop_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_ready <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
            done      <= finish_c;
            rd_vld    <= issue_c;
            if (state == IDLE && cmd_valid) begin
                base_q  <= cmd_base;
                count_q <= cmd_count;
                loop_q  <= cmd_loop;
            end
            if (issue_c) begin
                rd_idx  <= rd_addr_c;
                rd_last <= last_c;
                if (last_c) begin
                    addr_q <= pass_base_c;
                    k_q    <= '0;
                end else begin
                    addr_q <= addr_inc_c;
                    k_q    <= pass_k_c + CW'(1);
                end
            end
        end
    end

    // Head register drives the stream; skid slot absorbs the read that lands during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            s_valid   <= 1'b0;
            s_data    <= '0;
            s_idx     <= '0;
            s_last    <= 1'b0;
        end else if (abort_c) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            s_valid   <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (s_valid) begin
                out_valid <= 1'b1;
                out_data  <= s_data;
                out_index <= s_idx;
                out_last  <= s_last;
                s_valid   <= rd_vld;
                if (rd_vld) begin
                    s_data <= mem_q;
                    s_idx  <= rd_idx;
                    s_last <= rd_last;
                end
            end else if (rd_vld) begin
                out_valid <= 1'b1;
                out_data  <= mem_q;
                out_index <= rd_idx;
                out_last  <= rd_last;
            end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end else if (rd_vld) begin
            s_valid <= 1'b1;
            s_data  <= mem_q;
            s_idx   <= rd_idx;
            s_last  <= rd_last;
        end
    end

endmodule

// File: tb/tb_sample_stream_mem.sv
// Scoreboard bench for sample_stream_mem: expected beats queued at command issue, checked at handshake.
// Exercises the write port only when SAMPLE_MEM_WRPORT_EN is defined.
module tb_sample_stream_mem;

    localparam int unsigned ENTRY_W = 32;
    localparam int unsigned DIM     = 4;
    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DW      = DIM * ENTRY_W;

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic              last;
        logic [DW-1:0]     data;
    } beat_t;

    logic              clk, rst;
    logic              cmd_valid, cmd_ready, cmd_loop, stop;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_count;
    logic              out_valid, out_ready, out_last, busy, done;
    logic [DW-1:0]     out_data;
    logic [ADDR_W-1:0] out_index;
`ifdef SAMPLE_MEM_WRPORT_EN
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DW-1:0]     wr_data;
`endif

    sample_stream_mem dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
        .cmd_count(cmd_count), .cmd_loop(cmd_loop), .stop(stop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
`ifdef SAMPLE_MEM_WRPORT_EN
        , .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`endif
    );

    beat_t             sb[$];
    beat_t             e;
    logic [DW-1:0]     model_mem [DEPTH];
    int                n_checks = 0, n_pass = 0, cyc = 0;
    int                hs_cnt, done_cnt, first_valid, done_cyc;
    logic              vld_at_done, hold, h_last, wr_on_accept;
    logic [DW-1:0]     h_data;
    logic [ADDR_W-1:0] h_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [DW-1:0] pattern(input int a);
        logic [DW-1:0] v;
        for (int j = 0; j < int'(DIM); j++) v[j*ENTRY_W +: ENTRY_W] = {16'(a), 16'(j)};
        return v;
    endfunction

    task automatic push_exp(input int a, input bit last);
        beat_t b;
        b.idx  = ADDR_W'(a);
        b.last = last;
        b.data = model_mem[a];
        sb.push_back(b);
    endtask

    // Output monitor: scoreboard compare on handshake, hold check on stalls, timing capture.
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check_eq("hold_valid", DW'(out_valid), DW'(1));
                check_eq("hold_data", out_data, h_data);
                check_eq("hold_index", DW'(out_index), DW'(h_idx));
                check_eq("hold_last", DW'(out_last), DW'(h_last));
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                check_eq("beat_expected", DW'(sb.size() != 0), DW'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("beat_index", DW'(out_index), DW'(e.idx));
                    check_eq("beat_data", out_data, e.data);
                    check_eq("beat_last", DW'(out_last), DW'(e.last));
                end
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_cnt++;
                done_cyc    = cyc;
                vld_at_done = out_valid;
            end
            hold   = out_valid && !out_ready && !stop;
            h_data = out_data;
            h_idx  = out_index;
            h_last = out_last;
        end
    end

    // mode 0: ready always; 1: ready pattern 1,0,0 repeating; 2: random ready.
    task automatic run_cmd(input int base, input int count, input bit loop, input int mode, input int stop_after);
        int acc, b, p, stop_cyc;
        bit stopped;
        if (loop) for (int n = 0; n < stop_after; n++) push_exp((base + n % count) % DEPTH, (n % count) == count - 1);
        else for (int n = 0; n < count; n++) push_exp((base + n) % DEPTH, n == count - 1);
        hs_cnt = 0; done_cnt = 0; first_valid = -1; done_cyc = -1; vld_at_done = 1'b0;
        @(posedge clk); #1;
        check_eq("cmd_ready_idle", DW'(cmd_ready), DW'(1));
        cmd_valid = 1'b1;
        cmd_base  = ADDR_W'(base);
        cmd_count = (ADDR_W+1)'(count);
        cmd_loop  = loop;
        acc = cyc;
`ifdef SAMPLE_MEM_WRPORT_EN
        if (wr_on_accept) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(base);
            wr_data = ~model_mem[base];
        end
`endif
        b = 0; p = 0; stopped = 1'b0; stop_cyc = -1;
        while (done_cnt == 0 && b < 400) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
`ifdef SAMPLE_MEM_WRPORT_EN
            if (wr_on_accept) begin
                wr_en = 1'b0;
                model_mem[base] = ~model_mem[base];
                wr_on_accept = 1'b0;
            end
`endif
            b++;
            if (b == 2 && count > 1) begin
                check_eq("busy_mid", DW'(busy), DW'(1));
                check_eq("cmd_ready_busy", DW'(cmd_ready), DW'(0));
            end
            if (loop && !stopped && hs_cnt >= stop_after) begin
                stop = 1'b1; out_ready = 1'b0; stopped = 1'b1; stop_cyc = cyc;
            end else begin
                stop = 1'b0;
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (p % 3 == 0);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                p++;
            end
        end
        check_eq("done_seen", DW'(done_cnt != 0), DW'(1));
        stop = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("done_once", DW'(done_cnt), DW'(1));
        check_eq("beat_count", DW'(hs_cnt), DW'(loop ? stop_after : count));
        check_eq("sb_empty", DW'(sb.size()), DW'(0));
        if (mode == 0 && !loop) begin
            if (count == 0) begin
                check_eq("no_valid", DW'(first_valid), DW'(-1));
                check_eq("done_lat0", DW'(done_cyc), DW'(acc + 1));
            end else begin
                check_eq("first_lat", DW'(first_valid), DW'(acc + 2));
                check_eq("done_lat", DW'(done_cyc), DW'(acc + 2 + count));
            end
        end
        if (loop) begin
            check_eq("stop_done_lat", DW'(done_cyc), DW'(stop_cyc + 1));
            check_eq("stop_valid_low", DW'(vld_at_done), DW'(0));
        end
        sb.delete();
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_count = '0; cmd_loop = 1'b0;
        stop = 1'b0; out_ready = 1'b1; wr_on_accept = 1'b0;
        hs_cnt = 0; done_cnt = 0; first_valid = -1; done_cyc = -1; hold = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = pattern(i);
`ifdef SAMPLE_MEM_WRPORT_EN
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(posedge clk); #1;
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = model_mem[i];
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
`else
        for (int i = 0; i < int'(DEPTH); i++) dut.mem[i] = model_mem[i];
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", DW'(cmd_ready), DW'(1));
        check_eq("rst_out_valid", DW'(out_valid), DW'(0));
        check_eq("rst_busy", DW'(busy), DW'(0));
        check_eq("rst_done", DW'(done), DW'(0));
        check_eq("rst_out_data", out_data, DW'(0));
        check_eq("rst_out_index", DW'(out_index), DW'(0));
        check_eq("rst_out_last", DW'(out_last), DW'(0));
        rst = 1'b0;

        // stop while idle must have no effect
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        @(negedge clk);
        check_eq("idle_stop_done", DW'(done), DW'(0));
        check_eq("idle_stop_ready", DW'(cmd_ready), DW'(1));

        run_cmd(0, 4, 1'b0, 0, 0);
        run_cmd(DEPTH - 2, 4, 1'b0, 0, 0);
        run_cmd(10, 3, 1'b0, 1, 0);
        run_cmd(5, 2, 1'b1, 0, 5);
        run_cmd(20, 0, 1'b0, 0, 0);
        run_cmd(0, 1, 1'b0, 0, 0);
        run_cmd(DEPTH - 1, 3, 1'b1, 2, 7);
        for (int r = 0; r < 4; r++)
            run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 12)), 1'b0, 2, 0);

`ifdef SAMPLE_MEM_WRPORT_EN
        wr_on_accept = 1'b1;
        run_cmd(7, 1, 1'b0, 0, 0);
        run_cmd(7, 1, 1'b0, 0, 0);
`endif

        // asynchronous reset in the middle of a stream
        for (int n = 0; n < 20; n++) push_exp(100 + n, n == 19);
        hs_cnt = 0; done_cnt = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_base = ADDR_W'(100); cmd_count = (ADDR_W+1)'(20); cmd_loop = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("pre_rst_busy", DW'(busy), DW'(1));
        check_eq("pre_rst_valid", DW'(out_valid), DW'(1));
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_valid", DW'(out_valid), DW'(0));
        check_eq("midrst_busy", DW'(busy), DW'(0));
        check_eq("midrst_cmd_ready", DW'(cmd_ready), DW'(1));
        check_eq("midrst_last", DW'(out_last), DW'(0));
        check_eq("midrst_index", DW'(out_index), DW'(0));
        check_eq("midrst_data", out_data, DW'(0));
        check_eq("midrst_done", DW'(done), DW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        check_eq("post_rst_valid", DW'(out_valid), DW'(0));
        check_eq("post_rst_done_cnt", DW'(done_cnt), DW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
